// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a 2-entry skid buffer.
// The head beat lives in the main register and a second beat can park in the skid register,
// so ready_o is a function of registered state only. A synchronous flush empties the stage
// without touching the data registers. A saturating counter tracks downstream stall cycles.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [1:0]        count_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] StallMax = '1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic acc;
    logic drn;

    // Handshake and outputs are gated by reset so the stage looks empty while held in reset.
    assign ready_o     = (state_q != StFull) & rst_n_i;
    assign valid_o     = (state_q != StEmpty) & rst_n_i;
    assign acc         = valid_i & ready_o;
    assign drn         = valid_o & ready_i;
    assign data_o      = rst_n_i ? main_data_q : '0;
    assign ctrl_o      = valid_o ? main_ctrl_q : '0;
    assign stall_cnt_o = stall_cnt_q;

    // Occupancy as a beat count.
    always_comb begin
        count_o = 2'd0;
        if (rst_n_i) begin
            unique case (state_q)
                StOne:   count_o = 2'd1;
                StFull:  count_o = 2'd2;
                default: count_o = 2'd0;
            endcase
        end
    end

    // Next-state and data-path selection; flush overrides any same-cycle accept or drain.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        unique case (state_q)
            StEmpty: begin
                if (acc) begin
                    state_d     = StOne;
                    main_data_d = data_i;
                    main_ctrl_d = ctrl_i;
                end
            end
            StOne: begin
                if (acc && drn) begin
                    main_data_d = data_i;
                    main_ctrl_d = ctrl_i;
                end else if (acc) begin
                    state_d     = StFull;
                    skid_data_d = data_i;
                    skid_ctrl_d = ctrl_i;
                end else if (drn) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (drn) begin
                    state_d     = StOne;
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                end
            end
            default: state_d = StEmpty;
        endcase

        if (flush_i) begin
            state_d     = StEmpty;
            main_data_d = main_data_q;
            main_ctrl_d = main_ctrl_q;
            skid_data_d = skid_data_q;
            skid_ctrl_d = skid_ctrl_q;
        end
    end

    // Saturating count of cycles where a valid head is blocked downstream.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid_o && !ready_i && !flush_i && (stall_cnt_q != StallMax)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= StEmpty;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a queue model predicts accepted beats at each rising edge,
// and a monitor on the falling edge compares outputs and pops beats as they drain.
module tb_pipe_stage_skid;

    localparam int DW = 32;
    localparam int CW = 2;
    localparam int NW = 4;
    localparam int StallSat = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          rst_n_i;
    logic          flush_i;
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] data_i;
    logic [CW-1:0] ctrl_i;
    logic          valid_o;
    logic          ready_i;
    logic [DW-1:0] data_o;
    logic [CW-1:0] ctrl_o;
    logic [1:0]    count_o;
    logic [NW-1:0] stall_cnt_o;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .DATA_W(DW),
        .CTRL_W(CW),
        .CNT_W (NW)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n_i),
        .flush_i    (flush_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_i     (data_i),
        .ctrl_i     (ctrl_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .ctrl_o     (ctrl_o),
        .count_o    (count_o),
        .stall_cnt_o(stall_cnt_o)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    int            checks = 0;
    int            errors = 0;
    beat_t         exp_q[$];
    int            mcount = 0;
    int            mstall = 0;
    logic [DW-1:0] last_head = '0;
    bit            started = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of at most two beats, updated at each rising edge.
    initial begin : model
        bit m_acc;
        bit m_drn;
        int prev;
        beat_t b;
        forever begin
            @(posedge clk);
            started = 1'b1;
            if (!rst_n_i) begin
                mcount    = 0;
                mstall    = 0;
                last_head = '0;
                exp_q.delete();
            end else if (flush_i) begin
                if (mcount > 0 && exp_q.size() > 0) last_head = exp_q[0].d;
                mcount = 0;
                exp_q.delete();
            end else begin
                prev  = mcount;
                m_drn = (prev > 0) && ready_i;
                m_acc = valid_i && (prev < 2);
                if (m_drn) mcount--;
                if (m_acc) begin
                    b.d = data_i;
                    b.c = ctrl_i;
                    exp_q.push_back(b);
                    mcount++;
                end
                if (prev > 0 && !ready_i && mstall < StallSat) mstall++;
            end
        end
    end

    // Monitor: compare visible state, then pop the head when it is drained at the next edge.
    initial begin : monitor
        beat_t b;
        logic [DW-1:0] ed;
        logic [CW-1:0] ec;
        forever begin
            @(negedge clk);
            if (started) begin
                check("stall_cnt_o", stall_cnt_o, mstall);
                if (!rst_n_i) begin
                    check("rst_valid_o", valid_o, 0);
                    check("rst_ready_o", ready_o, 0);
                    check("rst_ctrl_o", ctrl_o, 0);
                    check("rst_data_o", data_o, 0);
                    check("rst_count_o", count_o, 0);
                end else begin
                    if (mcount > 0 && exp_q.size() > 0) begin
                        ed = exp_q[0].d;
                        ec = exp_q[0].c;
                    end else begin
                        ed = last_head;
                        ec = '0;
                    end
                    check("ready_o", ready_o, (mcount < 2) ? 1 : 0);
                    check("valid_o", valid_o, (mcount > 0) ? 1 : 0);
                    check("count_o", count_o, mcount);
                    check("data_o", data_o, ed);
                    check("ctrl_o", ctrl_o, ec);
                    if (valid_o === 1'b1 && ready_i && !flush_i) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL drain: beat %0h emitted, none expected at %0t",
                                     data_o, $time);
                        end else begin
                            b = exp_q.pop_front();
                            check("drain_data", data_o, b.d);
                            check("drain_ctrl", ctrl_o, b.c);
                            last_head = b.d;
                        end
                    end
                end
            end
        end
    end

    task automatic cyc(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input bit r, input bit f, input bit rs);
        valid_i = v;
        data_i  = d;
        ctrl_i  = c;
        ready_i = r;
        flush_i = f;
        rst_n_i = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        // T1: reset held with a valid offer
        cyc(1, 32'hAA, 2'b11, 1, 0, 0);
        cyc(1, 32'hAA, 2'b11, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 1);
        #3 check("t1_ready_after_release", ready_o, 1);

        // T2: back-to-back streaming
        for (int i = 0; i < 8; i++) cyc(1, i, 2'b11, 1, 0, 1);
        cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 1, 0, 1);

        // T3: skid fill then drain
        cyc(1, 32'hA, 2'b01, 0, 0, 1);
        cyc(1, 32'hB, 2'b10, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        #3 check("t3_count_full", count_o, 2);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 1);

        // T4: flush of a full stage with a same-cycle offer
        cyc(1, 32'hA4, 2'b11, 0, 0, 1);
        cyc(1, 32'hB4, 2'b11, 0, 0, 1);
        cyc(1, 32'hC4, 2'b11, 1, 1, 1);
        #3 check("t4_valid_after_flush", valid_o, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 1);

        // T5: stall counter saturation
        cyc(1, 32'h55, 2'b01, 0, 0, 1);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 1);
        #3 check("t5_stall_sat", stall_cnt_o, StallSat);
        cyc(0, 0, 0, 1, 0, 1);

        // T6: reset while full, then a normal beat
        cyc(1, 32'h61, 2'b01, 0, 0, 1);
        cyc(1, 32'h62, 2'b10, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 32'h63, 2'b11, 1, 0, 1);
        cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 1, 0, 1);

        // Randomised traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 9) < 7, $urandom, CW'($urandom_range(0, 3)),
                $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
                $urandom_range(0, 49) != 0);
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
